alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Issue-side ALU control stage: the producer of the 4-bit ALUOp consumed by the boolean/arith ALU units.
- Accepts decoded instruction fields (opcode, funct, shamt) over a valid/ready handshake.
- Registers ALUOp, operand-B select and shift amount for the execute stage.
- Sequences the multi-cycle MULT path by stalling issue while the multiplier runs.

Parameters:
- MULT_CYCLES, 4, number of cycles the multiplier is busy after a MULT issues (legal range 1..15)
- CNT_W, 4, width of the busy down-counter; must satisfy 2^CNT_W > MULT_CYCLES

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction fields valid
- in_ready  output  1  stage can accept
- opcode  input  6  instruction[31:26]
- funct  input  6  instruction[5:0]
- shamt  input  5  instruction[10:6]
- out_valid  output  1  registered control valid
- out_ready  input  1  execute stage accepts
- alu_op  output  4  ALUOp code
- srcb_imm  output  1  1 = operand B from immediate
- shamt_o  output  5  shift amount to ALU
- illegal  output  1  unsupported encoding (alu_op = 0000)
- mul_start  output  1  one-cycle pulse on MULT handshake
- busy  output  1  multiplier sequencing in progress

Behaviour:
- Reset (async, reset_n=0): out_valid=0, alu_op=0000, srcb_imm=0, shamt_o=0, illegal=0, mul_start=0, busy=0, counter=0, FSM=RUN. Reset mid-MULT aborts the wait immediately.
- ALUOp encoding: PASSA 1010, AND 1000, NOR 0001, OR 1110, XNOR 1001, XOR 0110, ADD 0010, SUB 0011, SLT 0111, SLL 0100, SRL 0101, SRA 1100, MULT 1101, NONE 0000.
- R-type decode (opcode 000000), by funct:
  - 0x20/0x21 ADD, 0x22/0x23 SUB
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x2A SLT
  - 0x00 SLL, 0x02 SRL, 0x03 SRA
  - 0x18 MULT
  - srcb_imm=0; shamt_o=shamt for shifts, else 0.
- I-type decode (srcb_imm=1, shamt_o=0 unless noted):
  - addi 0x08, lw 0x23, sw 0x2B -> ADD
  - andi 0x0C AND, ori 0x0D OR, xori 0x0E XOR
  - slti 0x0A SLT
  - lui 0x0F -> SLL with shamt_o=16
- beq 0x04 -> SUB with srcb_imm=0.
- Any other opcode or funct: alu_op=0000, illegal=1, srcb_imm=0, shamt_o=0. The encoding still flows through the handshake; no stall.
- XNOR and PASSA are never produced by decode. Their codes are reserved for microcode and test use.
- Pipeline: one register stage. Latency is 1 cycle from the accepting edge to out_valid.
- in_ready = (FSM==RUN) & (~out_valid | out_ready).
- Accept when in_valid & in_ready. Output fields update only on accept.
- If there is no accept and the output handshake completes, out_valid clears.
- Output fields hold stable while out_valid & ~out_ready (no change under backpressure).
- FSM RUN -> MWAIT on the output handshake (out_valid & out_ready) with alu_op==MULT:
  - mul_start=1 in that same cycle (combinational from the handshake)
  - counter loads MULT_CYCLES on that edge
- FSM MWAIT:
  - busy=1 and in_ready=0
  - counter decrements each cycle
  - when counter==1 on an edge, go to RUN and set counter=0
- Timing: busy is high for exactly MULT_CYCLES cycles, and in_ready rises in the cycle after busy falls.
- Simultaneous events: a MULT handshake blocks any same-cycle accept. in_ready is forced to 0 combinationally when the held output is MULT and out_ready=1, so nothing issues behind a MULT.
- in_valid ignored while in_ready=0. Upstream must hold its fields.

Decomposition:
- Package alu_pkg:
  - ALUOp localparams (the codes above)
  - opcode/funct constants
  - typedef alu_ctrl_t {alu_op, srcb_imm, shamt_o, illegal}
- Sub-module alu_decode: purely combinational opcode/funct/shamt -> alu_ctrl_t.
- Top level holds the pipeline register, FSM and counter.

Test Plan:
- Reset with in_valid=1 opcode=0 funct=0x24 -> all outputs 0 during reset; 1 cycle after release out_valid=1, alu_op=1000, srcb_imm=0.
- Back-to-back with out_ready=1: ori (0x0D), then lui (0x0F), then R sra shamt=7 -> consecutive outputs 1110/imm=1; 0100/shamt_o=16/imm=1; 1100/shamt_o=7; in_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles after nor (funct 0x27) -> out_valid=1, alu_op=0001 stable, in_ready=0; release -> next instruction accepted the same cycle.
- MULT, MULT_CYCLES=4, followed by add pending -> mul_start one pulse on the handshake; busy=1 for 4 cycles; in_ready=0 throughout; add accepted the cycle after busy drops; out alu_op=0010.
- Illegal: opcode 0x3F -> out_valid=1, alu_op=0000, illegal=1, no stall. R funct 0x3F behaves the same.
- Assert reset_n low in the 2nd MWAIT cycle -> busy=0 and out_valid=0 immediately. After release, in_ready=1 with FSM=RUN.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUOp codes, instruction field constants and the decoded control bundle
// for the issue-side ALU control stage.
package alu_pkg;

  localparam logic [3:0] ALU_NONE  = 4'b0000;
  localparam logic [3:0] ALU_NOR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_AND   = 4'b1000;
  localparam logic [3:0] ALU_XNOR  = 4'b1001;
  localparam logic [3:0] ALU_PASSA = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1100;
  localparam logic [3:0] ALU_MULT  = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b1110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] LUI_SHAMT = 5'd16;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       srcb_imm;
    logic [4:0] shamt_o;
    logic       illegal;
  } alu_ctrl_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MWAIT = 1'b1
  } seq_state_t;

  function automatic alu_ctrl_t mk_ctrl(input logic [3:0] op, input logic imm,
                                        input logic [4:0] sh);
    alu_ctrl_t c;
    c.alu_op   = op;
    c.srcb_imm = imm;
    c.shamt_o  = sh;
    c.illegal  = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct/shamt decode into the ALU control bundle.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  output alu_ctrl_t  ctrl
);

  always_comb begin
    // Unsupported encodings fall through to NONE with the illegal flag set.
    ctrl         = '0;
    ctrl.illegal = 1'b1;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: ctrl = mk_ctrl(ALU_ADD,  1'b0, '0);
        FN_SUB, FN_SUBU: ctrl = mk_ctrl(ALU_SUB,  1'b0, '0);
        FN_AND:          ctrl = mk_ctrl(ALU_AND,  1'b0, '0);
        FN_OR:           ctrl = mk_ctrl(ALU_OR,   1'b0, '0);
        FN_XOR:          ctrl = mk_ctrl(ALU_XOR,  1'b0, '0);
        FN_NOR:          ctrl = mk_ctrl(ALU_NOR,  1'b0, '0);
        FN_SLT:          ctrl = mk_ctrl(ALU_SLT,  1'b0, '0);
        FN_SLL:          ctrl = mk_ctrl(ALU_SLL,  1'b0, shamt);
        FN_SRL:          ctrl = mk_ctrl(ALU_SRL,  1'b0, shamt);
        FN_SRA:          ctrl = mk_ctrl(ALU_SRA,  1'b0, shamt);
        FN_MULT:         ctrl = mk_ctrl(ALU_MULT, 1'b0, '0);
        default: ;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_LW, OP_SW: ctrl = mk_ctrl(ALU_ADD, 1'b1, '0);
        OP_ANDI:               ctrl = mk_ctrl(ALU_AND, 1'b1, '0);
        OP_ORI:                ctrl = mk_ctrl(ALU_OR,  1'b1, '0);
        OP_XORI:               ctrl = mk_ctrl(ALU_XOR, 1'b1, '0);
        OP_SLTI:               ctrl = mk_ctrl(ALU_SLT, 1'b1, '0);
        OP_LUI:                ctrl = mk_ctrl(ALU_SLL, 1'b1, LUI_SHAMT);
        OP_BEQ:                ctrl = mk_ctrl(ALU_SUB, 1'b0, '0);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Issue-side ALU control stage: one register stage behind a valid/ready handshake,
// stalling issue while the multi-cycle multiplier runs.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_op,
  output logic       srcb_imm,
  output logic [4:0] shamt_o,
  output logic       illegal,
  output logic       mul_start,
  output logic       busy
);

  alu_ctrl_t  dec;
  alu_ctrl_t  ctrl_q;
  seq_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic accept;
  logic mul_hs;

  alu_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .shamt  (shamt),
    .ctrl   (dec)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    mul_hs    = (state == ST_RUN) && out_valid && out_ready && (ctrl_q.alu_op == ALU_MULT);
    mul_start = mul_hs;
    busy      = (state == ST_MWAIT);
    // A MULT leaving the register blocks any same-cycle issue behind it.
    in_ready  = (state == ST_RUN) && (!out_valid || out_ready) && !mul_hs;
    accept    = in_valid && in_ready;
    case (state)
      ST_RUN: begin
        if (mul_hs) begin
          state_nx = ST_MWAIT;
          cnt_nx   = CNT_W'(MULT_CYCLES);
        end
      end
      ST_MWAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl_q    <= dec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_op   = ctrl_q.alu_op;
  assign srcb_imm = ctrl_q.srcb_imm;
  assign shamt_o  = ctrl_q.shamt_o;
  assign illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: expected control words are queued on accept
// and compared when the output handshake completes.
module tb_alu_ctrl_seq;

  localparam int unsigned MC = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_op;
  logic       srcb_imm;
  logic [4:0] shamt_o;
  logic       illegal;
  logic       mul_start;
  logic       busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [10:0] sb_q[$];
  int unsigned cyc = 0, last_acc = 0, last_busy = 0;
  int unsigned busy_cycles = 0, ms_pulses = 0, ms_bad = 0, ir_busy_viol = 0;

  alu_ctrl_seq #(.MULT_CYCLES(MC), .CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct     (funct),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .srcb_imm  (srcb_imm),
    .shamt_o   (shamt_o),
    .illegal   (illegal),
    .mul_start (mul_start),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: {alu_op, srcb_imm, shamt_o, illegal}
  function automatic logic [10:0] model(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] sh);
    logic [3:0] a;
    logic       imm;
    logic [4:0] s;
    logic       il;
    a = 4'b0000; imm = 1'b0; s = 5'd0; il = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: a = 4'b0010;
        6'h22, 6'h23: a = 4'b0011;
        6'h24: a = 4'b1000;
        6'h25: a = 4'b1110;
        6'h26: a = 4'b0110;
        6'h27: a = 4'b0001;
        6'h2A: a = 4'b0111;
        6'h00: begin a = 4'b0100; s = sh; end
        6'h02: begin a = 4'b0101; s = sh; end
        6'h03: begin a = 4'b1100; s = sh; end
        6'h18: a = 4'b1101;
        default: il = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08, 6'h23, 6'h2B: begin a = 4'b0010; imm = 1'b1; end
        6'h0C: begin a = 4'b1000; imm = 1'b1; end
        6'h0D: begin a = 4'b1110; imm = 1'b1; end
        6'h0E: begin a = 4'b0110; imm = 1'b1; end
        6'h0A: begin a = 4'b0111; imm = 1'b1; end
        6'h0F: begin a = 4'b0100; imm = 1'b1; s = 5'd16; end
        6'h04: a = 4'b0011;
        default: il = 1'b1;
      endcase
    end
    return {a, imm, s, il};
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      cyc++;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_out", {21'd0, alu_op, srcb_imm, shamt_o, illegal}, {21'd0, sb_q.pop_front()});
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(opcode, funct, shamt));
        last_acc = cyc;
      end
      if (busy) begin
        busy_cycles++;
        last_busy = cyc;
        if (in_ready) ir_busy_viol++;
      end
      if (mul_start) begin
        ms_pulses++;
        if (!(out_valid && out_ready && alu_op == 4'b1101)) ms_bad++;
      end
    end
  end

  // Called at posedge+1; returns the number of cycles spent waiting for in_ready.
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                      output int unsigned waits);
    waits    = 0;
    in_valid = 1'b1;
    opcode   = op;
    funct    = fn;
    shamt    = sh;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [5:0]  t_op[7] = '{6'h00, 6'h04, 6'h0A, 6'h23, 6'h00, 6'h00, 6'h0C};
  logic [5:0]  t_fn[7] = '{6'h22, 6'h11, 6'h00, 6'h3F, 6'h02, 6'h26, 6'h05};
  logic [4:0]  t_sh[7] = '{5'd4,  5'd0,  5'd9,  5'd0,  5'd3,  5'd1,  5'd2};

  initial begin
    int unsigned n;
    int unsigned k;
    reset_n = 1'b0; in_valid = 1'b1; opcode = 6'h00; funct = 6'h24; shamt = 5'd0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {out_valid, alu_op, srcb_imm, shamt_o, illegal, mul_start, busy}, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_first_valid", out_valid, 1);
    chk("rst_first_op", {alu_op, srcb_imm}, {4'b1000, 1'b0});
    in_valid = 1'b0;

    send(6'h0D, 6'h00, 5'd0, n); chk("b2b_ready0", n, 0);
    send(6'h0F, 6'h00, 5'd0, n); chk("b2b_ready1", n, 0);
    send(6'h00, 6'h03, 5'd7, n); chk("b2b_ready2", n, 0);

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(6'h00, 6'h27, 5'd0, n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, alu_op, in_ready}, {1'b1, 4'b0001, 1'b0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(6'h00, 6'h20, 5'd0, n); chk("bp_release_accept", n, 0);

    busy_cycles = 0; ms_pulses = 0; ms_bad = 0; ir_busy_viol = 0;
    send(6'h00, 6'h18, 5'd0, n);
    send(6'h00, 6'h21, 5'd0, n);
    chk("mult_wait", n, MC + 1);
    chk("mult_busy_cycles", busy_cycles, MC);
    chk("mult_start_pulses", ms_pulses, 1);
    chk("mult_start_align", ms_bad, 0);
    chk("mult_inready_busy", ir_busy_viol, 0);
    chk("mult_accept_after", last_acc, last_busy + 1);

    send(6'h3F, 6'h00, 5'd0, n); chk("ill_op_nostall", n, 0);
    send(6'h00, 6'h3F, 5'd9, n); chk("ill_fn_nostall", n, 0);
    for (int i = 0; i < 7; i++) begin
      send(t_op[i], t_fn[i], t_sh[i], n);
      chk("table_nostall", n, 0);
    end

    send(6'h00, 6'h18, 5'd0, n);
    k = 0;
    @(negedge clk);
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mwait_reached", busy, 1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mult", {busy, out_valid, mul_start}, 3'b000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_recover", {in_ready, busy}, 2'b10);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
